// File: rtl/layer_run_ctrl.sv
// layer_run_ctrl: turns host go/halt/abort into the conv top's start pulse and halt level, counting active cycles.
// Optional watchdog is compiled in with `define RUN_CTRL_WATCHDOG_EN.
module layer_run_ctrl #(
   parameter int          CYC_W       = 32,
   parameter int unsigned TIMEOUT_CYC = 'd100000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             host_go,
   input  logic             host_halt,
   input  logic             host_abort,
   input  logic             core_done,
   output logic             start,
   output logic             halt,
   output logic             busy,
   output logic             done,
   output logic             timeout_err,
   output logic [CYC_W-1:0] run_cycles
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_RUN    = 3'd2,
      S_PAUSE  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_start;
   logic             r_halt;
   logic             r_busy;
   logic             r_done;
   logic [CYC_W-1:0] r_run_cycles;
   logic             w_go_acc;
   logic             w_wd_trip;
   logic             w_wd_hit;
   logic             w_cnt_en;

   if (CYC_W < 1 || TIMEOUT_CYC < 1 ||
       64'(TIMEOUT_CYC) > ((64'd1 << CYC_W) - 64'd1)) begin : g_bad_param
      $error("layer_run_ctrl: TIMEOUT_CYC out of range for CYC_W");
   end

`ifdef RUN_CTRL_WATCHDOG_EN
   logic r_timeout_err;
   assign w_wd_trip = (r_run_cycles == CYC_W'(TIMEOUT_CYC));
`else
   assign w_wd_trip = 1'b0;
`endif

   assign w_go_acc = (r_state == S_IDLE) && host_go;
   assign w_wd_hit = (r_state == S_RUN) && !core_done && w_wd_trip;
   // the trip edge itself is not counted, so run_cycles reports the limit that fired
   assign w_cnt_en = (r_state == S_RUN) && !w_wd_hit && (r_run_cycles != {CYC_W{1'b1}});

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // next-state decode; core_done > watchdog > abort > halt
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (host_go) w_next = S_LAUNCH;
            else         w_next = S_IDLE;
         end
         S_LAUNCH: w_next = S_RUN;
         S_RUN: begin
            if (core_done)       w_next = S_DONE;
            else if (w_wd_hit)   w_next = S_IDLE;
            else if (host_abort) w_next = S_IDLE;
            else if (host_halt)  w_next = S_PAUSE;
            else                 w_next = S_RUN;
         end
         S_PAUSE: begin
            if (core_done)       w_next = S_DONE;
            else if (host_abort) w_next = S_IDLE;
            else if (!host_halt) w_next = S_RUN;
            else                 w_next = S_PAUSE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // outputs registered from the next state so they line up with state entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_start <= 1'b0;
         r_halt  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_start <= (w_next == S_LAUNCH);
         r_halt  <= (w_next == S_PAUSE);
         r_busy  <= (w_next != S_IDLE);
         r_done  <= (w_next == S_DONE);
      end
   end

   // active-cycle counter, cleared on accepted go, saturating
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_run_cycles <= {CYC_W{1'b0}};
      end else if (w_go_acc) begin
         r_run_cycles <= {CYC_W{1'b0}};
      end else if (w_cnt_en) begin
         r_run_cycles <= r_run_cycles + {{(CYC_W-1){1'b0}}, 1'b1};
      end else begin
         r_run_cycles <= r_run_cycles;
      end
   end

`ifdef RUN_CTRL_WATCHDOG_EN
   // sticky watchdog flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_timeout_err <= 1'b0;
      end else if (w_go_acc) begin
         r_timeout_err <= 1'b0;
      end else if (w_wd_hit) begin
         r_timeout_err <= 1'b1;
      end else begin
         r_timeout_err <= r_timeout_err;
      end
   end
   assign timeout_err = r_timeout_err;
`else
   assign timeout_err = 1'b0;
`endif

   assign start      = r_start;
   assign halt       = r_halt;
   assign busy       = r_busy;
   assign done       = r_done;
   assign run_cycles = r_run_cycles;

endmodule

// File: tb/tb_layer_run_ctrl.sv
// Self-checking bench for layer_run_ctrl: vector table through a scoreboard queue plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_layer_run_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        host_go = 1'b0, host_halt = 1'b0, host_abort = 1'b0, core_done = 1'b0;
   logic        start_a, halt_a, busy_a, done_a, terr_a;
   logic [31:0] rc_a;
   logic        start_b, halt_b, busy_b, done_b, terr_b;
   logic [3:0]  rc_b;

   layer_run_ctrl #(.CYC_W(32), .TIMEOUT_CYC(20)) dut_a (
      .clk(clk), .rst(rst), .host_go(host_go), .host_halt(host_halt),
      .host_abort(host_abort), .core_done(core_done), .start(start_a), .halt(halt_a),
      .busy(busy_a), .done(done_a), .timeout_err(terr_a), .run_cycles(rc_a));

   layer_run_ctrl #(.CYC_W(4), .TIMEOUT_CYC(15)) dut_b (
      .clk(clk), .rst(rst), .host_go(host_go), .host_halt(host_halt),
      .host_abort(host_abort), .core_done(core_done), .start(start_b), .halt(halt_b),
      .busy(busy_b), .done(done_b), .timeout_err(terr_b), .run_cycles(rc_b));

   always #5 clk = ~clk;

   typedef struct {
      logic go, hl, ab, cd;
      logic st, ha, bu, dn;
      logic [31:0] rc;
   } vec_t;

   vec_t vecs[$];
   vec_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void add(input logic go, hl, ab, cd, st, ha, bu, dn, input logic [31:0] rc);
      vec_t v;
      v.go = go; v.hl = hl; v.ab = ab; v.cd = cd;
      v.st = st; v.ha = ha; v.bu = bu; v.dn = dn; v.rc = rc;
      vecs.push_back(v);
   endfunction

   task automatic cyc(input logic go, hl, ab, cd);
      @(negedge clk);
      host_go = go; host_halt = hl; host_abort = ab; core_done = cd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t e;
      repeat (5) @(posedge clk);
      #1;
      chk("rst start", start_a, 0); chk("rst halt", halt_a, 0);
      chk("rst busy", busy_a, 0);   chk("rst done", done_a, 0);
      chk("rst terr", terr_a, 0);   chk("rst rc", rc_a, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      chk("release busy", busy_a, 0); chk("release start", start_a, 0);

      // basic run, go ignored in RUN and in DONE
      add(1,0,0,0, 1,0,1,0, 0);
      add(0,0,0,0, 0,0,1,0, 0);
      for (int k = 1; k <= 9; k++) add((k == 4), 0,0,0, 0,0,1,0, k);
      add(0,0,0,1, 0,0,1,1, 10);
      add(1,0,0,0, 0,0,0,0, 10);
      // pause for 4 cycles, 10 active cycles total
      add(1,0,0,0, 1,0,1,0, 0);
      add(0,0,0,0, 0,0,1,0, 0);
      for (int k = 1; k <= 4; k++) add(0,0,0,0, 0,0,1,0, k);
      add(0,1,0,0, 0,1,1,0, 5);
      for (int k = 0; k < 3; k++) add(0,1,0,0, 0,1,1,0, 5);
      add(0,0,0,0, 0,0,1,0, 5);
      for (int k = 6; k <= 9; k++) add(0,0,0,0, 0,0,1,0, k);
      add(0,0,0,1, 0,0,1,1, 10);
      add(0,0,0,0, 0,0,0,0, 10);
      // done ignored in IDLE/LAUNCH; done+abort+halt collision
      add(0,0,0,1, 0,0,0,0, 10);
      add(1,0,0,0, 1,0,1,0, 0);
      add(0,0,0,1, 0,0,1,0, 0);
      add(0,0,0,0, 0,0,1,0, 1);
      add(0,1,1,1, 0,0,1,1, 2);
      add(0,0,0,0, 0,0,0,0, 2);
      // abort in PAUSE, then abort in RUN
      add(1,0,0,0, 1,0,1,0, 0);
      add(0,0,0,0, 0,0,1,0, 0);
      add(0,0,0,0, 0,0,1,0, 1);
      add(0,1,0,0, 0,1,1,0, 2);
      add(0,1,1,0, 0,0,0,0, 2);
      add(0,0,0,0, 0,0,0,0, 2);
      add(1,0,0,0, 1,0,1,0, 0);
      add(0,0,0,0, 0,0,1,0, 0);
      add(0,0,1,0, 0,0,0,0, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         host_go = vecs[i].go; host_halt = vecs[i].hl;
         host_abort = vecs[i].ab; core_done = vecs[i].cd;
         sb_q.push_back(vecs[i]);
         @(posedge clk);
         #1;
         e = sb_q.pop_front();
         chk($sformatf("v%0d start", i), start_a, e.st);
         chk($sformatf("v%0d halt", i),  halt_a,  e.ha);
         chk($sformatf("v%0d busy", i),  busy_a,  e.bu);
         chk($sformatf("v%0d done", i),  done_a,  e.dn);
         chk($sformatf("v%0d rc", i),    rc_a,    e.rc);
         chk($sformatf("v%0d terr", i),  terr_a,  0);
      end

      // long run: watchdog trip or, without it, continued RUN and saturation of the narrow counter
      cyc(1,0,0,0);
      chk("long start", start_a, 1);
      cyc(0,0,0,0);
      repeat (25) cyc(0,0,0,0);
      chk("sat rc_b", rc_b, 15);
`ifdef RUN_CTRL_WATCHDOG_EN
      chk("wd busy", busy_a, 0);
      chk("wd rc", rc_a, 20);
      chk("wd terr", terr_a, 1);
      chk("wd done", done_a, 0);
      cyc(1,0,0,0);
      chk("wd terr clr", terr_a, 0);
      chk("wd restart", start_a, 1);
      cyc(0,0,0,0);
      cyc(0,0,1,0);
      chk("wd abort busy", busy_a, 0);
`else
      chk("nowd busy", busy_a, 1);
      chk("nowd rc", rc_a, 25);
      chk("nowd terr", terr_a, 0);
      cyc(0,0,0,1);
      chk("nowd done", done_a, 1);
      chk("nowd done rc", rc_a, 26);
      cyc(0,0,0,0);
      chk("nowd idle", busy_a, 0);
`endif

      // async reset mid-RUN
      cyc(1,0,0,0);
      cyc(0,0,0,0);
      cyc(0,0,0,0);
      cyc(0,0,0,0);
      chk("pre-rst rc", rc_a, 2);
      chk("pre-rst busy", busy_a, 1);
      #3;
      rst = 1'b1;
      #1;
      chk("arst start", start_a, 0); chk("arst halt", halt_a, 0);
      chk("arst busy", busy_a, 0);   chk("arst done", done_a, 0);
      chk("arst terr", terr_a, 0);   chk("arst rc", rc_a, 0);
      chk("arst rc_b", rc_b, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post-rst start", start_a, 0);
      chk("post-rst busy", busy_a, 0);
      chk("post-rst done", done_a, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
